// File: rtl/tetris_input_pkg.sv
// Shared types and default timing for the push-button input path of the game datapath.
package tetris_input_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_e;

  typedef enum logic {
    DIR_LEFT,
    DIR_RIGHT
  } dir_e;

  // Bit positions of the four buttons in the packed key vectors.
  localparam int KEY_LEFT   = 3;
  localparam int KEY_RIGHT  = 2;
  localparam int KEY_ROTATE = 1;
  localparam int KEY_START  = 0;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
  localparam int unsigned DEF_DB_W            = 18;
  localparam int unsigned DEF_REPEAT_DELAY    = 12;
  localparam int unsigned DEF_REPEAT_PERIOD   = 4;
  localparam int unsigned DEF_RPT_W           = 5;

endpackage

// File: rtl/key_debouncer.sv
// One button: two-flop synchronizer, stability counter, accepted level and a one-clock press pulse.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned DB_W            = 18
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o
);

  logic            sync1_q, sync2_q;
  logic            acc_q, acc_d;
  logic            prev_q;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            level_s;

  assign level_s = ~sync2_q;

  // The counter only runs while the synced level disagrees with the accepted one,
  // so any bounce back to the accepted level restarts the stability window.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (level_s == acc_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      acc_d = level_s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      acc_q   <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      acc_q   <= acc_d;
      prev_q  <= acc_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = acc_q;
  assign press_o = acc_q & ~prev_q;

endmodule

// File: rtl/key_conditioner.sv
// Debounced buttons -> frame-aligned move/rotate/start requests with DAS auto-repeat on left/right.
module key_conditioner
  import tetris_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned DB_W            = DEF_DB_W,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned RPT_W           = DEF_RPT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic frame_tick,
  input  logic key_left_n,
  input  logic key_right_n,
  input  logic key_rotate_n,
  input  logic key_start_n,
  output logic key_left,
  output logic key_right,
  output logic key_rotate,
  output logic start_game
);

  logic [3:0] raw_n, lvl, press;
  logic       unused_lvl;

  assign raw_n = {key_left_n, key_right_n, key_rotate_n, key_start_n};
  assign unused_lvl = ^lvl[KEY_ROTATE:KEY_START];

  for (genvar k = 0; k < 4; k++) begin : g_db
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_W           (DB_W)
    ) u_db (
      .clk_i  (clock),
      .rst_i  (reset),
      .key_n_i(raw_n[k]),
      .level_o(lvl[k]),
      .press_o(press[k])
    );
  end

  rpt_state_e       state_q, state_d;
  dir_e             dir_q, dir_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_limit;
  logic             set_l, set_r, held_lvl, opp_press;
  logic [3:0]       pend_q, pend_d, out_q, out_d, set_vec;

  assign held_lvl  = (dir_q == DIR_LEFT) ? lvl[KEY_LEFT] : lvl[KEY_RIGHT];
  assign opp_press = (dir_q == DIR_LEFT) ? press[KEY_RIGHT] : press[KEY_LEFT];
  assign rpt_limit = (state_q == DELAY) ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1);

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    rpt_cnt_d = rpt_cnt_q;
    set_l     = 1'b0;
    set_r     = 1'b0;
    case (state_q)
      IDLE: begin
        // Simultaneous left+right is ambiguous, so neither is honoured.
        if (press[KEY_LEFT] ^ press[KEY_RIGHT]) begin
          dir_d     = press[KEY_LEFT] ? DIR_LEFT : DIR_RIGHT;
          set_l     = press[KEY_LEFT];
          set_r     = press[KEY_RIGHT];
          rpt_cnt_d = '0;
          state_d   = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (opp_press) begin
          dir_d     = (dir_q == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
          set_l     = (dir_q == DIR_RIGHT);
          set_r     = (dir_q == DIR_LEFT);
          rpt_cnt_d = '0;
          state_d   = DELAY;
        end else if (!held_lvl) begin
          state_d = IDLE;
        end else if (frame_tick) begin
          if (rpt_cnt_q == rpt_limit) begin
            set_l     = (dir_q == DIR_LEFT);
            set_r     = (dir_q == DIR_RIGHT);
            rpt_cnt_d = '0;
            state_d   = REPEAT;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Requests raised in the tick cycle itself survive into the next frame.
  always_comb begin
    set_vec = {set_l, set_r, press[KEY_ROTATE], press[KEY_START]};
    pend_d  = pend_q | set_vec;
    out_d   = out_q;
    if (frame_tick) begin
      pend_d              = set_vec;
      out_d[KEY_LEFT]     = pend_q[KEY_LEFT]  & (~pend_q[KEY_RIGHT] | (dir_q == DIR_LEFT));
      out_d[KEY_RIGHT]    = pend_q[KEY_RIGHT] & (~pend_q[KEY_LEFT]  | (dir_q == DIR_RIGHT));
      out_d[KEY_ROTATE]   = pend_q[KEY_ROTATE];
      out_d[KEY_START]    = pend_q[KEY_START];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      dir_q     <= DIR_LEFT;
      rpt_cnt_q <= '0;
      pend_q    <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      rpt_cnt_q <= rpt_cnt_d;
      pend_q    <= pend_d;
      out_q     <= out_d;
    end
  end

  assign key_left   = out_q[KEY_LEFT];
  assign key_right  = out_q[KEY_RIGHT];
  assign key_rotate = out_q[KEY_ROTATE];
  assign start_game = out_q[KEY_START];

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios then random button activity, checked each cycle against a reference model.
module tb_key_conditioner;

  localparam int DB     = 4;
  localparam int DB_W   = 3;
  localparam int RD     = 3;
  localparam int RP     = 2;
  localparam int RPT_W  = 5;
  localparam int TICK_P = 10;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0;
  logic key_left_n = 1'b1, key_right_n = 1'b1, key_rotate_n = 1'b1, key_start_n = 1'b1;
  logic key_left, key_right, key_rotate, start_game;
  logic chk_en = 1'b0;
  int   tick_cnt = 0;

  always #5 clock = ~clock;

  key_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .DB_W           (DB_W),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .RPT_W          (RPT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .key_left_n  (key_left_n),
    .key_right_n (key_right_n),
    .key_rotate_n(key_rotate_n),
    .key_start_n (key_start_n),
    .key_left    (key_left),
    .key_right   (key_right),
    .key_rotate  (key_rotate),
    .start_game  (start_game)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Key bit order everywhere: [3]=left [2]=right [1]=rotate [0]=start, 1 = pressed.
  // m_hold: 0 = no held direction, 1 = left, 2 = right.
  logic [3:0] m_hist[$];
  logic [3:0] m_acc, m_rise, m_pend, m_out;
  int         m_hold, m_last_dir, m_ticks_left;

  function automatic void model_init();
    m_hist.delete();
    for (int i = 0; i < DB + 2; i++) m_hist.push_back(4'b0000);
    m_acc        = '0;
    m_rise       = '0;
    m_pend       = '0;
    m_out        = '0;
    m_hold       = 0;
    m_last_dir   = 1;
    m_ticks_left = 0;
  endfunction

  function automatic void model_step(input logic t, input logic [3:0] pressed);
    logic [3:0] ev, req;
    logic       all_diff;
    int         hb;
    ev  = m_rise;
    req = {2'b00, ev[1:0]};
    if (t) begin
      m_out[3]   = m_pend[3] && (!m_pend[2] || m_last_dir == 1);
      m_out[2]   = m_pend[2] && (!m_pend[3] || m_last_dir == 2);
      m_out[1:0] = m_pend[1:0];
    end
    if (m_hold != 0) begin
      hb = (m_hold == 1) ? 3 : 2;
      if ((m_hold == 1 && ev[2]) || (m_hold == 2 && ev[3])) begin
        m_hold       = 3 - m_hold;
        hb           = (m_hold == 1) ? 3 : 2;
        req[hb]      = 1'b1;
        m_ticks_left = RD;
      end else if (!m_acc[hb]) begin
        m_hold = 0;
      end else if (t) begin
        m_ticks_left--;
        if (m_ticks_left == 0) begin
          req[hb]      = 1'b1;
          m_ticks_left = RP;
        end
      end
    end else if (ev[3] != ev[2]) begin
      m_hold       = ev[3] ? 1 : 2;
      hb           = ev[3] ? 3 : 2;
      req[hb]      = 1'b1;
      m_ticks_left = RD;
    end
    if (m_hold != 0) m_last_dir = m_hold;
    m_pend = t ? req : (m_pend | req);
    // Accepted level flips once the last DB synchronized samples all disagree with it.
    m_hist.push_front(pressed);
    void'(m_hist.pop_back());
    m_rise = '0;
    for (int k = 0; k < 4; k++) begin
      all_diff = 1'b1;
      for (int j = 2; j < DB + 2; j++) if (m_hist[j][k] == m_acc[k]) all_diff = 1'b0;
      if (all_diff) begin
        m_acc[k]  = ~m_acc[k];
        m_rise[k] = m_acc[k];
      end
    end
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) model_init();
    else model_step(frame_tick, {~key_left_n, ~key_right_n, ~key_rotate_n, ~key_start_n});
  end

  // ---------------- scoreboard: every cycle ----------------
  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) check_eq("outputs", {key_left, key_right, key_rotate, start_game}, m_out);
    end
  end

  // ---------------- frame tick generator ----------------
  initial begin
    forever begin
      @(negedge clock);
      tick_cnt   = (tick_cnt + 1) % TICK_P;
      frame_tick = (tick_cnt == 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hold_keys(input logic [3:0] mask, input int cycles);
    @(negedge clock);
    key_left_n   = ~mask[3];
    key_right_n  = ~mask[2];
    key_rotate_n = ~mask[1];
    key_start_n  = ~mask[0];
    repeat (cycles - 1) @(negedge clock);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_eq("reset_now", {key_left, key_right, key_rotate, start_game}, 4'b0000);
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0] mask;
    int         len;
    model_init();
    repeat (3) @(negedge clock);
    check_eq("reset_state", {key_left, key_right, key_rotate, start_game}, 4'b0000);
    reset  = 1'b0;
    chk_en = 1'b1;

    hold_keys(4'b0010, 3);    // short rotate glitch
    hold_keys(4'b0000, 30);
    hold_keys(4'b0010, 40);   // single-shot rotate
    hold_keys(4'b0000, 30);
    hold_keys(4'b1000, 100);  // left auto-repeat
    hold_keys(4'b0000, 30);
    hold_keys(4'b1000, 70);   // left into repeat, then right takes over
    hold_keys(4'b1100, 60);
    hold_keys(4'b0000, 30);
    hold_keys(4'b1110, 40);   // left+right together, rotate alongside
    hold_keys(4'b0000, 30);
    hold_keys(4'b0001, 25);   // start
    hold_keys(4'b0000, 20);
    hold_keys(4'b1000, 70);   // reset mid-repeat with left held
    pulse_reset();
    hold_keys(4'b1000, 40);
    hold_keys(4'b0000, 30);

    repeat (150) begin
      mask = 4'($urandom_range(0, 15));
      len  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 60);
      hold_keys(mask, len);
      if ($urandom_range(0, 40) == 0) pulse_reset();
    end
    hold_keys(4'b0000, 30);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
